// File: rtl/window3x3_gen_if.sv
// Pixel-stream / 3x3-window bundle between a raster source, window3x3_gen and its consumer.
interface window3x3_gen_if;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned POS_W = 10;

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic [PIX_W-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic             win_valid;
  logic [POS_W-1:0] win_row;
  logic [POS_W-1:0] win_col;
  logic             frame_done;

  modport master (
    output pix_in, pix_valid,
    input  z0, z1, z2, z3, z4, z5, z6, z7, z8,
    input  win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output z0, z1, z2, z3, z4, z5, z6, z7, z8,
    output win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window3x3_gen.sv
// Raster pixel stream to 3x3 interior neighbourhoods using two line buffers and a 3x3 shift register.
module window3x3_gen #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128
) (
  input logic           clk,
  input logic           rst,
  window3x3_gen_if.slave bus
);
  localparam int unsigned PIX_W = 8;
  localparam int unsigned POS_W = 10;
  localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [POS_W-1:0] col, row;
  logic [AW-1:0]    col_idx;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [9];
  logic             pend_valid, pend_done;
  logic [POS_W-1:0] pend_row, pend_col;
  logic             acc, last_col, last_row, frame_end_c, emit_c;

  always_comb begin
    col_idx     = col[AW-1:0];
    acc         = bus.pix_valid;
    last_col    = (col == POS_W'(IMG_W - 1));
    last_row    = (row == POS_W'(IMG_H - 1));
    frame_end_c = acc && last_col && last_row;
  end

  // Next state and window-complete strobe
  always_comb begin
    state_nx = state;
    emit_c   = 1'b0;
    case (state)
      FILL: begin
        if (acc && last_col && (row == POS_W'(1))) state_nx = RUN;
      end
      RUN: begin
        emit_c = acc && (col >= POS_W'(2));
        if (frame_end_c) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  // Line buffers: read-before-write rotates the previous row down one slot
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[col_idx] <= lb1[col_idx];
      lb1[col_idx] <= bus.pix_in;
    end
  end

  // Position counters, window shift register and the stage that feeds the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pend_valid <= 1'b0;
      pend_done  <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else begin
      pend_valid <= emit_c;
      pend_done  <= frame_end_c;
      if (acc) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + POS_W'(1);
        end else begin
          col <= col + POS_W'(1);
        end
        win[0]   <= win[1];
        win[1]   <= win[2];
        win[2]   <= lb0[col_idx];
        win[3]   <= win[4];
        win[4]   <= win[5];
        win[5]   <= lb1[col_idx];
        win[6]   <= win[7];
        win[7]   <= win[8];
        win[8]   <= bus.pix_in;
        pend_row <= row - POS_W'(1);
        pend_col <= col - POS_W'(1);
      end
    end
  end

  // Output registers hold between accepted pixels because their sources do
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.z0         <= '0;
      bus.z1         <= '0;
      bus.z2         <= '0;
      bus.z3         <= '0;
      bus.z4         <= '0;
      bus.z5         <= '0;
      bus.z6         <= '0;
      bus.z7         <= '0;
      bus.z8         <= '0;
      bus.win_valid  <= 1'b0;
      bus.win_row    <= '0;
      bus.win_col    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.z0         <= win[0];
      bus.z1         <= win[1];
      bus.z2         <= win[2];
      bus.z3         <= win[3];
      bus.z4         <= win[4];
      bus.z5         <= win[5];
      bus.z6         <= win[6];
      bus.z7         <= win[7];
      bus.z8         <= win[8];
      bus.win_valid  <= pend_valid;
      bus.win_row    <= pend_row;
      bus.win_col    <= pend_col;
      bus.frame_done <= pend_done;
    end
  end
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: a 5x4 and a 3x3 instance checked against an image-array model.
module tb_window3x3_gen;
  typedef struct packed {
    logic [8:0][7:0] z;
    logic [9:0]      r;
    logic [9:0]      c;
    logic            dn;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window3x3_gen_if if5 ();
  window3x3_gen_if if3 ();

  window3x3_gen #(.IMG_W(5), .IMG_H(4)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
  window3x3_gen #(.IMG_W(3), .IMG_H(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  int img_w [2] = '{5, 3};
  int img_h [2] = '{4, 3};
  logic [7:0] img [2][4][5];
  int mrow [2];
  int mcol [2];
  bit started [2];
  // p*: outcome of the most recent accepted pixel; e*: what the outputs must show now
  bit pv [2], pd [2], pk [2], ev [2], ed [2], ek [2];
  logic [8:0][7:0] pz [2], ez [2];
  logic [9:0] pr [2], pc [2], er [2], ec [2];

  win_t q5 [$];
  win_t q3 [$];

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic r, input logic v, input logic [7:0] p);
    if (r) begin
      started[d] = 1'b1;
      ev[d] = 1'b0; ed[d] = 1'b0; ek[d] = 1'b1;
      ez[d] = '0;   er[d] = '0;   ec[d] = '0;
      pv[d] = 1'b0; pd[d] = 1'b0; pk[d] = 1'b0;
      mrow[d] = 0;  mcol[d] = 0;
    end else begin
      ev[d] = pv[d]; ed[d] = pd[d]; ek[d] = pk[d];
      ez[d] = pz[d]; er[d] = pr[d]; ec[d] = pc[d];
      pv[d] = 1'b0;  pd[d] = 1'b0;
      if (v === 1'b1) begin
        img[d][mrow[d]][mcol[d]] = p;
        if (mrow[d] >= 2 && mcol[d] >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              pz[d][i*3+j] = img[d][mrow[d]-2+i][mcol[d]-2+j];
          pv[d] = 1'b1;
          pk[d] = 1'b1;
          pr[d] = 10'(mrow[d] - 1);
          pc[d] = 10'(mcol[d] - 1);
        end else begin
          pk[d] = 1'b0;
        end
        pd[d] = (mrow[d] == img_h[d] - 1) && (mcol[d] == img_w[d] - 1);
        if (mcol[d] == img_w[d] - 1) begin
          mcol[d] = 0;
          mrow[d] = (mrow[d] == img_h[d] - 1) ? 0 : mrow[d] + 1;
        end else begin
          mcol[d] = mcol[d] + 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst, if5.pix_valid, if5.pix_in);
    model_step(1, rst, if3.pix_valid, if3.pix_in);
  end

  task automatic cmp(input int d, input logic [8:0][7:0] z, input logic v, input logic dn,
                     input logic [9:0] r, input logic [9:0] c);
    string nm;
    win_t  w;
    nm = (d == 0) ? "w5" : "w3";
    if (!started[d]) return;
    check({nm, "_win_valid"}, 72'(v), 72'(ev[d]));
    check({nm, "_frame_done"}, 72'(dn), 72'(ed[d]));
    if (ek[d]) begin
      check({nm, "_z"}, 72'(z), 72'(ez[d]));
      check({nm, "_win_row"}, 72'(r), 72'(er[d]));
      check({nm, "_win_col"}, 72'(c), 72'(ec[d]));
    end
    if (v === 1'b1) begin
      w.z = z; w.r = r; w.c = c; w.dn = dn;
      if (d == 0) q5.push_back(w);
      else        q3.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, {if5.z8, if5.z7, if5.z6, if5.z5, if5.z4, if5.z3, if5.z2, if5.z1, if5.z0},
        if5.win_valid, if5.frame_done, if5.win_row, if5.win_col);
    cmp(1, {if3.z8, if3.z7, if3.z6, if3.z5, if3.z4, if3.z3, if3.z2, if3.z1, if3.z0},
        if3.win_valid, if3.frame_done, if3.win_row, if3.win_col);
  end

  task automatic drive(input int d, input logic v, input logic [7:0] p);
    @(negedge clk);
    if (d == 0) begin if5.pix_valid = v; if5.pix_in = p; end
    else        begin if3.pix_valid = v; if3.pix_in = p; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if5.pix_valid = 1'b0;
      if3.pix_valid = 1'b0;
    end
  endtask

  task automatic frame5(input int base, input bit gaps);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        if (gaps)
          while ($urandom_range(0, 1) == 0) drive(0, 1'b0, 8'($urandom));
        drive(0, 1'b1, 8'(base + r*5 + c));
      end
  endtask

  // Windows of 5x4 frames arrive row-major over centres (1..2, 1..3)
  task automatic check_list(input string nm, input int n_exp, input int base_a, input int base_b);
    logic [8:0][7:0] zx;
    int f, idx, r, c, base;
    check({nm, "_count"}, 72'(q5.size()), 72'(n_exp));
    for (int k = 0; k < q5.size() && k < n_exp; k++) begin
      f    = k / 6;
      idx  = k % 6;
      r    = 1 + idx / 3;
      c    = 1 + idx % 3;
      base = (f == 0) ? base_a : base_b;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          zx[i*3+j] = 8'(base + (r - 1 + i)*5 + (c - 1 + j));
      check({nm, "_z"}, 72'(q5[k].z), 72'(zx));
      check({nm, "_row"}, 72'(q5[k].r), 72'(r));
      check({nm, "_col"}, 72'(q5[k].c), 72'(c));
      check({nm, "_done"}, 72'(q5[k].dn), 72'(idx == 5));
    end
  endtask

  initial begin
    rst = 1'b1;
    if5.pix_valid = 1'b0; if5.pix_in = '0;
    if3.pix_valid = 1'b0; if3.pix_in = '0;
    repeat (2) @(negedge clk);
    check("reset_win_valid", 72'(if5.win_valid), 72'(0));
    check("reset_frame_done", 72'(if5.frame_done), 72'(0));
    check("reset_z4", 72'(if5.z4), 72'(0));
    check("reset_win_row", 72'(if5.win_row), 72'(0));
    rst = 1'b0;

    // Smoke and last window
    q5.delete();
    frame5(0, 1'b0);
    idle(3);
    check_list("smoke", 6, 0, 0);
    if (q5.size() == 6) begin
      check("smoke_first_z", 72'(q5[0].z), 72'h0c0b0a_070605_020100);
      check("smoke_first_pos", 72'({q5[0].r, q5[0].c}), 72'({10'd1, 10'd1}));
      check("smoke_last_z", 72'(q5[5].z), 72'h131211_0e0d0c_090807);
      check("smoke_last_pos", 72'({q5[5].r, q5[5].c}), 72'({10'd2, 10'd3}));
      check("smoke_last_done", 72'(q5[5].dn), 72'(1));
    end

    // Random 50% valid gaps
    q5.delete();
    frame5(0, 1'b1);
    idle(3);
    check_list("gaps", 6, 0, 0);

    // Back-to-back frames
    q5.delete();
    frame5(0, 1'b0);
    frame5(100, 1'b0);
    idle(3);
    check_list("b2b", 12, 0, 100);
    if (q5.size() == 12)
      check("b2b_f2_first_z", 72'(q5[6].z), 72'h706f6e_6b6a69_666564);

    // Reset mid-frame
    for (int k = 0; k < 9; k++) drive(0, 1'b1, 8'(k));
    @(negedge clk);
    if5.pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_win_valid", 72'(if5.win_valid), 72'(0));
    check("midrst_z", 72'({if5.z8, if5.z7, if5.z6, if5.z5, if5.z4, if5.z3, if5.z2, if5.z1, if5.z0}), 72'(0));
    check("midrst_pos", 72'({if5.win_row, if5.win_col}), 72'(0));
    rst = 1'b0;
    q5.delete();
    frame5(0, 1'b0);
    idle(3);
    check_list("after_rst", 6, 0, 0);

    // Minimum 3x3 image
    q3.delete();
    for (int k = 0; k < 9; k++) drive(1, 1'b1, 8'(10 + k));
    idle(3);
    check("min_count", 72'(q3.size()), 72'(1));
    if (q3.size() == 1) begin
      check("min_z", 72'(q3[0].z), 72'h121110_0f0e0d_0c0b0a);
      check("min_pos", 72'({q3[0].r, q3[0].c}), 72'({10'd1, 10'd1}));
      check("min_done", 72'(q3[0].dn), 72'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
